// File: rtl/wb_trace_fifo.sv
// Trace capture FIFO: packs register-writeback and data-memory events into tagged
// entries and drains them over valid/ready. Define TRACE_TIMESTAMP_EN to store per-entry cycle stamps.
module wb_trace_fifo #(
    parameter int DEPTH     = 16,
    parameter int DROP_W    = 8,
    parameter int CYC_W     = 32,
    parameter bit FILTER_X0 = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       reg_write_sig,
    input  logic [4:0]                 reg_num,
    input  logic [31:0]                reg_data,
    input  logic                       wr,
    input  logic                       rd,
    input  logic [8:0]                 addr,
    input  logic [31:0]                wr_data,
    input  logic [31:0]                rd_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [1:0]                 out_kind,
    output logic [8:0]                 out_idx,
    output logic [31:0]                out_data,
    output logic [CYC_W-1:0]           out_cycle,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [DROP_W-1:0]          drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [1:0] KIND_REG = 2'd0;

    logic [1:0]        kind_mem [DEPTH];
    logic [8:0]        idx_mem  [DEPTH];
    logic [31:0]       data_mem [DEPTH];

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     mem_ptr;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     free_w;
    logic [DROP_W-1:0] drop_q;
    logic              overflow_q;

    logic              reg_ev;
    logic              mem_ev;
    logic [1:0]        mem_kind;
    logic [31:0]       mem_data;
    logic              push_reg;
    logic              push_mem;
    logic              pop;
    logic [1:0]        n_drop;
    logic [DROP_W:0]   drop_sum;

    assign reg_ev   = reg_write_sig && !(FILTER_X0 && (reg_num == 5'd0));
    assign mem_ev   = wr || rd;
    // {wr,rd} maps directly onto MEM_RD=1, MEM_WR=2, MEM_CONFLICT=3
    assign mem_kind = {wr, rd};
    assign mem_data = wr ? wr_data : rd_data;

    // Space is judged on the count at the start of the cycle; a same-cycle pop does not help.
    assign free_w    = CW'(DEPTH) - count_q;
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;
    assign mem_ptr   = wr_ptr + AW'(push_reg);

    always_comb begin
        push_reg = 1'b0;
        push_mem = 1'b0;
        n_drop   = 2'd0;
        if (free_w >= CW'(2)) begin
            push_reg = reg_ev;
            push_mem = mem_ev;
        end else if (free_w == CW'(1)) begin
            push_reg = reg_ev;
            push_mem = mem_ev && !reg_ev;
            n_drop   = {1'b0, mem_ev && reg_ev};
        end else begin
            n_drop   = 2'(reg_ev) + 2'(mem_ev);
        end
    end

    assign drop_sum = {1'b0, drop_q} + (DROP_W+1)'(n_drop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            drop_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr + AW'(push_reg) + AW'(push_mem);
            rd_ptr  <= rd_ptr + AW'(pop);
            count_q <= count_q + CW'(push_reg) + CW'(push_mem) - CW'(pop);
            if (n_drop != 2'd0) begin
                overflow_q <= 1'b1;
            end
            drop_q <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
        end
    end

    // Payload storage needs no reset; only entries between the pointers are ever presented.
    always_ff @(posedge clk) begin
        if (push_reg) begin
            kind_mem[wr_ptr] <= KIND_REG;
            idx_mem[wr_ptr]  <= {4'b0, reg_num};
            data_mem[wr_ptr] <= reg_data;
        end
        if (push_mem) begin
            kind_mem[mem_ptr] <= mem_kind;
            idx_mem[mem_ptr]  <= addr;
            data_mem[mem_ptr] <= mem_data;
        end
    end

    assign out_kind   = out_valid ? kind_mem[rd_ptr] : 2'd0;
    assign out_idx    = out_valid ? idx_mem[rd_ptr]  : 9'd0;
    assign out_data   = out_valid ? data_mem[rd_ptr] : 32'd0;
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;

`ifdef TRACE_TIMESTAMP_EN
    logic [CYC_W-1:0] cycle_q;
    logic [CYC_W-1:0] cyc_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_q + CYC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_reg) begin
            cyc_mem[wr_ptr] <= cycle_q;
        end
        if (push_mem) begin
            cyc_mem[mem_ptr] <= cycle_q;
        end
    end

    assign out_cycle = out_valid ? cyc_mem[rd_ptr] : '0;
`else
    assign out_cycle = '0;
`endif

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Scoreboard bench for wb_trace_fifo: directed cases plus random traffic against a queue model.
module tb_wb_trace_fifo;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        reg_write_sig;
    logic [4:0]  reg_num;
    logic [31:0] reg_data;
    logic        wr;
    logic        rd;
    logic [8:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_kind;
    logic [8:0]  out_idx;
    logic [31:0] out_data;
    logic [31:0] out_cycle;
    logic [4:0]  count;
    logic        overflow;
    logic [7:0]  drop_count;

    wb_trace_fifo dut (
        .clk(clk), .reset(reset), .reg_write_sig(reg_write_sig), .reg_num(reg_num),
        .reg_data(reg_data), .wr(wr), .rd(rd), .addr(addr), .wr_data(wr_data),
        .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_kind(out_kind), .out_idx(out_idx), .out_data(out_data),
        .out_cycle(out_cycle), .count(count), .overflow(overflow), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  kind;
        logic [8:0]  idx;
        logic [31:0] data;
        logic [31:0] cyc;
    } ent_t;

    ent_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   m_count;
    int   m_drop;
    bit   m_ovf;
    int   m_cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted head entry is compared with the oldest expected entry.
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("out_kind", 32'(out_kind), 32'(e.kind));
                    chk("out_idx", 32'(out_idx), 32'(e.idx));
                    chk("out_data", out_data, e.data);
                    chk("out_cycle", out_cycle, e.cyc);
                end
            end
        end
    end

    function automatic ent_t mk(input logic [1:0] k, input logic [8:0] i, input logic [31:0] d, input int c);
        ent_t e;
        e.kind = k;
        e.idx  = i;
        e.data = d;
`ifdef TRACE_TIMESTAMP_EN
        e.cyc  = 32'(c);
`else
        e.cyc  = 32'd0;
`endif
        return e;
    endfunction

    task automatic check_state(input string tag);
        chk({tag, "_count"}, 32'(count), 32'(m_count));
        chk({tag, "_valid"}, 32'(out_valid), 32'(m_count != 0));
        chk({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
        chk({tag, "_drop"}, 32'(drop_count), 32'(m_drop));
    endtask

    // Called #1 after a rising edge; applies one cycle of stimulus and advances the model.
    task automatic step(input logic rw, input logic [4:0] rn, input logic [31:0] rdat,
                        input logic w, input logic r, input logic [8:0] a,
                        input logic [31:0] wd, input logic [31:0] rdd, input logic rdy);
        ent_t evs[$];
        int   fr;
        int   nd;
        int   ns;
        reg_write_sig = rw; reg_num = rn; reg_data = rdat;
        wr = w; rd = r; addr = a; wr_data = wd; rd_data = rdd; out_ready = rdy;
        if (rw && rn != 5'd0) evs.push_back(mk(2'd0, {4'b0, rn}, rdat, m_cyc));
        if (w || r) evs.push_back(mk({w, r}, a, w ? wd : rdd, m_cyc));
        fr = DEPTH - m_count;
        nd = 0;
        ns = 0;
        foreach (evs[i]) begin
            if (fr > 0) begin
                sb.push_back(evs[i]);
                fr--;
                ns++;
            end else begin
                nd++;
            end
        end
        m_count = m_count + ns - ((m_count > 0 && rdy) ? 1 : 0);
        m_drop  = (m_drop + nd > 255) ? 255 : m_drop + nd;
        if (nd > 0) m_ovf = 1'b1;
        @(posedge clk);
        #1;
        m_cyc++;
        check_state("cyc");
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 9'd0, 32'd0, 32'd0, rdy);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        out_ready = 1'b0;
        reg_write_sig = 1'b0; wr = 1'b0; rd = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        m_count = 0; m_drop = 0; m_ovf = 1'b0; m_cyc = 0;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);
        chk("rst_kind", 32'(out_kind), 32'd0);
        chk("rst_idx", 32'(out_idx), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_cycle", out_cycle, 32'd0);
    endtask

    task automatic rand_step(input int p_reg, input int p_mem, input int p_rdy);
        logic rw, w, r;
        rw = ($urandom_range(99) < p_reg);
        w  = 1'b0;
        r  = 1'b0;
        if ($urandom_range(99) < p_mem) begin
            w = $urandom_range(1);
            r = $urandom_range(1);
            if (!w && !r) r = 1'b1;
        end
        step(rw, 5'($urandom), $urandom, w, r, 9'($urandom), $urandom, $urandom,
             ($urandom_range(99) < p_rdy));
    endtask

    initial begin
        reset = 1'b1;
        reg_write_sig = 1'b0; reg_num = '0; reg_data = '0;
        wr = 1'b0; rd = 1'b0; addr = '0; wr_data = '0; rd_data = '0; out_ready = 1'b0;
        m_count = 0; m_drop = 0; m_ovf = 1'b0; m_cyc = 0;
        @(posedge clk);
        #1;
        do_reset();

        // single REG event drains the cycle after capture
        step(1'b1, 5'd5, 32'h2A, 1'b0, 1'b0, 9'd0, 32'd0, 32'd0, 1'b1);
        chk("t1_valid", 32'(out_valid), 32'd1);
        idle(1'b1);
        chk("t1_empty", 32'(count), 32'd0);

        // REG and MEM_WR in one cycle, REG first
        step(1'b1, 5'd3, 32'h11, 1'b1, 1'b0, 9'h40, 32'hDEAD, 32'd0, 1'b0);
        chk("t2_count", 32'(count), 32'd2);
        repeat (3) idle(1'b1);

        // fill to one free slot, then REG+MEM_RD: MEM dropped
        do_reset();
        for (int i = 0; i < 15; i++)
            step(1'b1, 5'(i + 1), 32'(i * 7), 1'b0, 1'b0, 9'd0, 32'd0, 32'd0, 1'b0);
        step(1'b1, 5'd20, 32'h77, 1'b0, 1'b1, 9'd9, 32'd0, 32'h99, 1'b0);
        chk("t3_count", 32'(count), 32'd16);
        chk("t3_drop1", 32'(drop_count), 32'd1);
        chk("t3_ovf", 32'(overflow), 32'd1);
        step(1'b1, 5'd21, 32'h78, 1'b0, 1'b0, 9'd0, 32'd0, 32'd0, 1'b0);
        chk("t3_drop2", 32'(drop_count), 32'd2);
        repeat (DEPTH + 2) idle(1'b1);

        // conflict entry carries wr_data; x0 write is filtered silently
        step(1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 9'd7, 32'h5, 32'hBAD, 1'b0);
        step(1'b1, 5'd0, 32'h1234, 1'b0, 1'b0, 9'd0, 32'd0, 32'd0, 1'b0);
        chk("t4_count", 32'(count), 32'd1);
        chk("t4_drop", 32'(drop_count), 32'd2);
        repeat (2) idle(1'b1);

        // reset mid-drain
        for (int i = 0; i < 8; i++)
            step(1'b1, 5'(i + 1), 32'(i), 1'b0, 1'b0, 9'd0, 32'd0, 32'd0, 1'b0);
        repeat (2) idle(1'b1);
        do_reset();
        idle(1'b1);

        // timestamps at capture cycles 3 and 10
        do_reset();
        repeat (3) idle(1'b0);
        step(1'b1, 5'd1, 32'hA, 1'b0, 1'b0, 9'd0, 32'd0, 32'd0, 1'b0);
        repeat (6) idle(1'b0);
        step(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 9'd3, 32'd0, 32'hB, 1'b0);
        repeat (3) idle(1'b1);

        // random traffic, alternating congested and free-flowing phases
        for (int ph = 0; ph < 8; ph++)
            for (int i = 0; i < 200; i++)
                rand_step(60, 50, (ph % 2 == 0) ? 20 : 85);

        // drop counter saturation
        for (int i = 0; i < 150; i++)
            step(1'b1, 5'd9, 32'(i), 1'b1, 1'b0, 9'd1, 32'(i), 32'd0, 1'b0);
        chk("drop_sat", 32'(drop_count), 32'hFF);
        repeat (DEPTH + 4) idle(1'b1);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
